mprc_store_gen_buf: RTL and testbench

//  Parametrised store-data generator with a small coalescing store buffer, between the LSU store port
//  and the data-array write port of the non-blocking cache. Each accepted store is aligned (data

---
 rtl/mprc_store_gen_buf.sv | 156 +++++++++++++++
 tb/tb_mprc_store_gen_buf.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mprc_store_gen_buf.sv
// Store-data generator feeding a small in-order store buffer for the cache data-array write port.
// Optional feature: define STORE_GEN_MERGE_EN to coalesce stores into the youngest entry's word.
module mprc_store_gen_buf #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 40,
   parameter int DEPTH  = 4,
   parameter int SZ_W   = 2,
   localparam int BYTES = DATA_W / 8,
   localparam int OFF_W = $clog2(BYTES),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [SZ_W-1:0]   req_size,
   input  logic [DATA_W-1:0] req_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic [BYTES-1:0]  out_mask,
   output logic [CNT_W-1:0]  count,
   output logic              misalign
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WORD_W = ADDR_W - OFF_W;

   function automatic logic [SZ_W-1:0] clamp_size(input logic [SZ_W-1:0] s);
      return (int'(s) > OFF_W) ? SZ_W'(OFF_W) : s;
   endfunction

   function automatic logic [BYTES-1:0] gen_mask(input logic [OFF_W-1:0] off,
                                                 input logic [SZ_W-1:0]  sz);
      logic [BYTES-1:0] m;
      int lo;
      int hi;
      lo = int'(off);
      hi = lo + (1 << int'(sz));
      for (int i = 0; i < BYTES; i++) begin
         m[i] = (i >= lo) && (i < hi);
      end
      return m;
   endfunction

   // Byte lane i takes source byte (i mod n), which replicates the low n bytes across the word.
   function automatic logic [DATA_W-1:0] gen_data(input logic [DATA_W-1:0] d,
                                                  input logic [SZ_W-1:0]   sz);
      logic [DATA_W-1:0] r;
      int sel;
      for (int i = 0; i < BYTES; i++) begin
         sel = i & ((1 << int'(sz)) - 1);
         r[8*i +: 8] = d[8*sel +: 8];
      end
      return r;
   endfunction

   function automatic logic is_misaligned(input logic [OFF_W-1:0] off,
                                          input logic [SZ_W-1:0]  sz);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < OFF_W; i++) begin
         if ((i < int'(sz)) && off[i]) bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   logic [WORD_W-1:0] ent_word [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [BYTES-1:0]  ent_mask [DEPTH];

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [SZ_W-1:0]   sz;
   logic [OFF_W-1:0]  off;
   logic [WORD_W-1:0] req_word;
   logic [BYTES-1:0]  new_mask;
   logic [DATA_W-1:0] new_data;
   logic              req_mis;
   logic              merge_ok;
   logic              accept;
   logic              do_push;
   logic              do_pop;

   assign sz       = clamp_size(req_size);
   assign off      = req_addr[OFF_W-1:0];
   assign req_word = req_addr[ADDR_W-1:OFF_W];
   assign new_mask = gen_mask(off, sz);
   assign new_data = gen_data(req_data, sz);
   assign req_mis  = is_misaligned(off, sz);

`ifdef STORE_GEN_MERGE_EN
   logic [PTR_W-1:0] yng;
   logic             do_merge;

   // Never merge into an entry that may be leaving this very cycle.
   assign yng      = (tail == '0) ? PTR_W'(DEPTH - 1) : tail - PTR_W'(1);
   assign merge_ok = (count != '0) && (req_word == ent_word[yng]) &&
                     !((count == CNT_W'(1)) && out_ready);
   assign do_merge = accept && !req_mis && merge_ok;
`else
   assign merge_ok = 1'b0;
`endif

   assign req_ready = (count < CNT_W'(DEPTH)) || merge_ok;
   assign accept    = req_valid && req_ready;
   assign do_push   = accept && !req_mis && !merge_ok;
   assign out_valid = (count != '0);
   assign do_pop    = out_valid && out_ready;

   assign out_addr  = out_valid ? {ent_word[head], OFF_W'(0)} : '0;
   assign out_data  = out_valid ? ent_data[head] : '0;
   assign out_mask  = out_valid ? ent_mask[head] : '0;

   // Entry payload carries no reset; validity is owned by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         ent_word[tail] <= req_word;
         ent_data[tail] <= new_data;
         ent_mask[tail] <= new_mask;
      end
`ifdef STORE_GEN_MERGE_EN
      if (do_merge) begin
         for (int i = 0; i < BYTES; i++) begin
            if (new_mask[i]) ent_data[yng][8*i +: 8] <= new_data[8*i +: 8];
         end
         ent_mask[yng] <= ent_mask[yng] | new_mask;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         misalign <= 1'b0;
      end else begin
         if (do_push) tail <= ptr_inc(tail);
         if (do_pop)  head <= ptr_inc(head);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         misalign <= accept && req_mis;
      end
   end

endmodule

// File: tb/tb_mprc_store_gen_buf.sv
// Scoreboard bench for mprc_store_gen_buf at default parameters (DATA_W=64, DEPTH=4).
// Merge expectations follow STORE_GEN_MERGE_EN when it is defined for the build.
module tb_mprc_store_gen_buf;

`ifdef STORE_GEN_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [39:0] req_addr;
   logic [1:0]  req_size;
   logic [63:0] req_data;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] out_addr;
   logic [63:0] out_data;
   logic [7:0]  out_mask;
   logic [2:0]  count;
   logic        misalign;

   typedef struct {
      logic [39:0] a;
      logic [63:0] d;
      logic [7:0]  m;
   } ent_t;

   ent_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_mis = 1'b0;
   bit   rnd_done;

   mprc_store_gen_buf dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_data  (req_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .count     (count),
      .misalign  (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] m_mask(input logic [2:0] off, input int sz);
      logic [8:0] t;
      t = ((9'd1 << (1 << sz)) - 9'd1) << off;
      return t[7:0];
   endfunction

   function automatic logic [63:0] m_data(input logic [63:0] d, input int sz);
      int          nb;
      logic [63:0] low;
      logic [63:0] r;
      nb  = 8 << sz;
      low = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
      r   = '0;
      for (int k = 0; k < 64 / nb; k++) r = (r << nb) | (d & low);
      return r;
   endfunction

   // Scoreboard: observe state between edges, then apply this cycle's handshakes to the model.
   always @(negedge clk) begin
      ent_t        e;
      ent_t        t;
      ent_t        h;
      int          sz;
      logic        mis;
      logic        mrg;
      logic        nxt_mis;
      logic [39:0] wa;
      if (!reset_n) begin
         q.delete();
         exp_mis = 1'b0;
      end else begin
         chk_eq("count", 64'(count), 64'(q.size()));
         chk_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk_eq("misalign", 64'(misalign), 64'(exp_mis));
         wa  = {req_addr[39:3], 3'b000};
         mrg = MERGE && (q.size() != 0) && (q[$].a == wa) && !((q.size() == 1) && out_ready);
         chk_eq("req_ready", 64'(req_ready), 64'((q.size() < 4) || mrg));
         nxt_mis = 1'b0;
         mis     = 1'b1;
         if (req_valid && req_ready) begin
            sz      = int'(req_size);
            mis     = (int'(req_addr[2:0]) % (1 << sz)) != 0;
            nxt_mis = mis;
            e.a = wa;
            e.m = m_mask(req_addr[2:0], sz);
            e.d = m_data(req_data, sz);
         end
         if (out_valid && out_ready && q.size() != 0) begin
            h = q.pop_front();
            chk_eq("out_addr", 64'(out_addr), 64'(h.a));
            chk_eq("out_data", out_data, h.d);
            chk_eq("out_mask", 64'(out_mask), 64'(h.m));
         end
         if (!mis) begin
            if (mrg) begin
               t = q[q.size()-1];
               for (int i = 0; i < 8; i++) if (e.m[i]) t.d[8*i +: 8] = e.d[8*i +: 8];
               t.m = t.m | e.m;
               q[q.size()-1] = t;
            end else begin
               q.push_back(e);
            end
         end
         exp_mis = nxt_mis;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [39:0] a, input logic [1:0] s, input logic [63:0] d);
      int waited;
      bit done;
      waited    = 0;
      done      = 0;
      req_valid = 1'b1;
      req_addr  = a;
      req_size  = s;
      req_data  = d;
      while (!done && waited < 200) begin
         @(negedge clk);
         done = req_ready;
         step();
         waited++;
      end
      req_valid = 1'b0;
      chk_eq("send_accept", 64'(done), 64'd1);
   endtask

   task automatic drain();
      int waited;
      waited    = 0;
      out_ready = 1'b1;
      while (count != 0 && waited < 100) begin
         step();
         waited++;
      end
      out_ready = 1'b0;
      chk_eq("drain", 64'(count), 64'd0);
   endtask

   task automatic align_case(input string tag, input logic [39:0] a, input logic [1:0] s,
                             input logic [63:0] d, input logic [7:0] em, input logic [63:0] ed);
      out_ready = 1'b0;
      send(a, s, d);
      chk_eq({tag, "_mask"}, 64'(out_mask), 64'(em));
      chk_eq({tag, "_data"}, out_data, ed);
      chk_eq({tag, "_addr"}, 64'(out_addr), 64'({a[39:3], 3'b000}));
      drain();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_size  = '0;
      req_data  = '0;
      out_ready = 1'b0;
      repeat (3) step();
      chk_eq("rst_count", 64'(count), 64'd0);
      chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
      chk_eq("rst_req_ready", 64'(req_ready), 64'd1);
      chk_eq("rst_out_addr", 64'(out_addr), 64'd0);
      chk_eq("rst_out_data", out_data, 64'd0);
      chk_eq("rst_out_mask", 64'(out_mask), 64'd0);
      chk_eq("rst_misalign", 64'(misalign), 64'd0);
      reset_n = 1'b1;
      step();

      align_case("byte", 40'h10_0000_1005, 2'd0, 64'h5555_5555_5555_55AB,
                 8'h20, 64'hABAB_ABAB_ABAB_ABAB);
      align_case("half", 40'h10_0000_2006, 2'd1, 64'h0000_0000_0000_1234,
                 8'hC0, 64'h1234_1234_1234_1234);
      align_case("word", 40'h10_0000_3004, 2'd2, 64'h7777_7777_DEAD_BEEF,
                 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF);
      align_case("dword", 40'h10_0000_4008, 2'd3, 64'h0123_4567_89AB_CDEF,
                 8'hFF, 64'h0123_4567_89AB_CDEF);

      // Misaligned halfword is taken but leaves no entry.
      send(40'h1003, 2'd1, 64'h5A5A);
      chk_eq("mis_pulse", 64'(misalign), 64'd1);
      chk_eq("mis_count", 64'(count), 64'd0);
      step();
      chk_eq("mis_clear", 64'(misalign), 64'd0);

      // Fill, hold a fifth store, free one slot, then the fifth goes in behind the others.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(40'h200 + 40'(8 * k), 2'd3, 64'h1111_0000 + 64'(k));
      chk_eq("full_count", 64'(count), 64'd4);
      chk_eq("full_ready", 64'(req_ready), 64'd0);
      req_valid = 1'b1;
      req_addr  = 40'h220;
      req_size  = 2'd3;
      req_data  = 64'h5555_0005;
      step();
      step();
      chk_eq("held_ready", 64'(req_ready), 64'd0);
      chk_eq("held_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_eq("pop_count", 64'(count), 64'd3);
      chk_eq("pop_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
      chk_eq("fifth_count", 64'(count), 64'd4);
      chk_eq("fifth_head", 64'(out_addr), 64'h208);
      drain();

      // Two byte stores into the same word.
      send(40'h100, 2'd0, 64'h11);
      send(40'h101, 2'd0, 64'h22);
      if (MERGE) begin
         chk_eq("mrg_count", 64'(count), 64'd1);
         chk_eq("mrg_mask", 64'(out_mask), 64'h03);
         chk_eq("mrg_data", 64'(out_data[15:0]), 64'h2211);
      end else begin
         chk_eq("nomrg_count", 64'(count), 64'd2);
         chk_eq("nomrg_mask0", 64'(out_mask), 64'h01);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         chk_eq("nomrg_mask1", 64'(out_mask), 64'h02);
      end
      drain();

      // Reset with traffic in flight.
      for (int k = 0; k < 3; k++) send(40'h400 + 40'(8 * k), 2'd2, 64'hCAFE_0000 + 64'(k));
      chk_eq("pre_rst_count", 64'(count), 64'd3);
      reset_n = 1'b0;
      #1;
      chk_eq("mid_rst_count", 64'(count), 64'd0);
      chk_eq("mid_rst_valid", 64'(out_valid), 64'd0);
      chk_eq("mid_rst_ready", 64'(req_ready), 64'd1);
      step();
      reset_n = 1'b1;
      step();

      // Random mix with random backpressure; the scoreboard checks every cycle.
      rnd_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 60; k++)
               send(40'h300 + 40'($urandom_range(0, 23)), 2'($urandom_range(0, 3)),
                    {$urandom, $urandom});
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(0, 2) != 0);
               step();
            end
         end
      join
      drain();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
